// File: rtl/switches_debounce_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the switch debounce/IRQ block.
// Signals: address, chipselect, write_n, writedata (to slave), readdata (from slave).
interface switches_debounce_irq_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/switches_debounce_irq_ctrl.sv
// Switch conditioner: 2-flop sync, tick-sampled debounce, edge capture, maskable IRQ.
// Ports: clk, reset_n (async low), bus (Avalon-MM slave), in_port (raw switches), irq.
module switches_debounce_irq_ctrl #(
    parameter int WIDTH          = 8,
    parameter int DEBOUNCE_TICKS = 50000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    switches_debounce_irq_ctrl_if.slave bus,
    input  logic [WIDTH-1:0]            in_port,
    output logic                        irq
);

    localparam int PW = $clog2(DEBOUNCE_TICKS);
    localparam int CW = $clog2(STABLE_SAMPLES);
    localparam logic [PW-1:0] PRE_LAST = PW'(DEBOUNCE_TICKS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [PW-1:0]    presc;
    logic             tick;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edges;
    logic [1:0]       ctrl;

    logic             wr;
    logic             wr_mask;
    logic             wr_edge;
    logic             wr_ctrl;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [31:0]      rd_mux;

    // Upper writedata bits are don't-care when WIDTH < 32.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, bus.writedata};

    assign tick    = (presc == PRE_LAST);
    assign wr      = bus.chipselect && !bus.write_n;
    assign wr_mask = wr && (bus.address == 2'd1);
    assign wr_edge = wr && (bus.address == 2'd2);
    assign wr_ctrl = wr && (bus.address == 2'd3);

    assign rise     = deb & ~deb_d;
    assign fall     = ~deb & deb_d;
    assign edge_set = (rise & {WIDTH{ctrl[0]}})
                    | (fall & {WIDTH{ctrl[1]}});
    assign edge_clr = wr_edge ? bus.writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            2'd0:    rd_mux = 32'(deb);
            2'd1:    rd_mux = 32'(mask);
            2'd2:    rd_mux = 32'(edges);
            default: rd_mux = {30'd0, ctrl};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta  <= '0;
            sync  <= '0;
            presc <= '0;
        end else begin
            meta  <= in_port;
            sync  <= meta;
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // A level is accepted only after STABLE_SAMPLES consecutive ticks
    // that all disagree with the current debounced value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            deb_d <= deb;
            if (tick) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (sync[i] != deb[i]) begin
                        if (cnt[i] == CNT_LAST) begin
                            deb[i] <= ~deb[i];
                            cnt[i] <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end else begin
                        cnt[i] <= '0;
                    end
                end
            end
        end
    end

    // Set has priority over a same-cycle software clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask         <= '0;
            edges        <= '0;
            ctrl         <= 2'b01;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            if (wr_mask) mask <= bus.writedata[WIDTH-1:0];
            if (wr_ctrl) ctrl <= bus.writedata[1:0];
            edges        <= (edges & ~edge_clr) | edge_set;
            irq          <= |(edges & mask);
            bus.readdata <= rd_mux;
        end
    end

endmodule

// File: doc/switches_debounce_irq_ctrl.md
# switches_debounce_irq_ctrl

Avalon-MM slave that conditions the 8 slide-switch inputs for the Nios II system. It synchronizes and debounces each switch and latches per-bit edge events. It raises a maskable interrupt, so software no longer polls the raw switch PIO. It sits between the board switch pins and the system interconnect, with one IRQ line to the processor.

## Interface
- `WIDTH`, 8: number of switch inputs (1..32).
- `DEBOUNCE_TICKS`, 50000: clocks per debounce sample tick (≥2); 1 ms at 50 MHz.
- `STABLE_SAMPLES`, 4: consecutive differing samples required to accept a new level (≥2).

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `in_port` in WIDTH: raw asynchronous switch levels.
- `readdata` out 32: registered read data, zero-extended.
- `irq` out 1: level interrupt, registered.

## Operation
- Register map:
  - 0 DATA (RO): debounced levels.
  - 1 MASK (RW, WIDTH bits): interrupt enable per bit.
  - 2 EDGE (R, write-1-to-clear): captured events.
  - 3 CTRL (RW): bit0 = capture rising edges, bit1 = capture falling edges; other bits read 0.
- Write occurs when `chipselect && !write_n`. Writes to DATA are ignored. Reads have no side effects.
- Synchronizer: 2 flops per bit, `in_port` → `sync`.
- Prescaler: counts 0..DEBOUNCE_TICKS-1 and wraps. `tick` pulses for one cycle at terminal count.
- Per-bit counter (width clog2(STABLE_SAMPLES)), evaluated on `tick`:
  - If `sync[i] != deb[i]`: counter increments.
  - When counter reaches STABLE_SAMPLES-1 on such a tick: `deb[i]` toggles and counter clears.
  - If `sync[i] == deb[i]` on a tick: counter clears, so a glitch restarts qualification.
- Edge capture: `deb_d` is `deb` delayed one cycle.
  - `rise = deb & ~deb_d`; `fall = ~deb & deb_d`.
  - `EDGE[i]` is set when (rise[i] && CTRL[0]) || (fall[i] && CTRL[1]).
- EDGE clear: a write with `writedata[i]`=1 clears `EDGE[i]`. If set and clear hit the same cycle, set wins.
- `irq <= |(EDGE & MASK)`. `irq` is a level signal that holds until software clears EDGE or MASK.
- Reset values:
  - `readdata` 0, `irq` 0.
  - DATA/`deb`/`deb_d` 0, MASK 0, EDGE 0, CTRL 2'b01.
  - Prescaler and counters 0, sync flops 0.
  - Reset mid-qualification discards partial counts. Asserting reset while `in_port` is held high produces no rising-edge event until a full qualification period has elapsed after release.

## Timing
- `readdata` is updated every clock from `address`, regardless of `chipselect`: one-cycle read latency, zero wait states.
- Writes take effect at the clock edge of the write cycle. A readback in the next cycle returns the new value.
- Debounce latency from `in_port` change to `deb` change:
  - At least 2 + DEBOUNCE_TICKS·(STABLE_SAMPLES-1) cycles.
  - At most 2 + DEBOUNCE_TICKS·STABLE_SAMPLES cycles.
- Downstream pipeline: `deb` change → EDGE set +1 cycle → `irq` +1 cycle.
- Clearing the last masked EDGE bit deasserts `irq` one cycle after the write edge.

## Test plan
Bench parameters: DEBOUNCE_TICKS=4, STABLE_SAMPLES=3.

1. **Reset values.** Assert `reset_n`=0 mid-run with `in_port`=8'hFF → `readdata`=0 and `irq`=0 immediately. Read CTRL → 1, MASK → 0, EDGE → 0.
2. **Rising edge with interrupt.** MASK=8'h01, set `in_port[0]` 0→1 and hold. DATA reads 8'h01 within 2+12 cycles, not before 2+8. EDGE=8'h01 the cycle after. `irq`=1 one cycle later.
3. **Glitch rejection.** Pulse `in_port[3]` high for 6 cycles (spanning ≤2 ticks) → DATA stays 0, EDGE stays 0, `irq` stays 0.
4. **Falling-edge selection.** CTRL=2'b10, toggle `in_port[5]` 0→1→0 with long holds. EDGE bit5 sets only on the 1→0 transition. With MASK=0 → `irq` stays 0.
5. **Clear versus new event.** EDGE=8'h03. Write EDGE=8'h01 in the same cycle that a new bit-0 rise is captured → EDGE=8'h03, set wins. A later write of 8'h03 with MASK=8'hFF → EDGE=0, `irq` drops after 1 cycle.
6. **Write-only behaviour of DATA.** Write DATA=8'hAA → DATA unchanged. Every cycle with `chipselect`=0 still returns the addressed register in `readdata` one cycle later.
